// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MAR/MDR memory access sequencer:
// state encoding, requester identities and the default timeout.
package mem_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LD_MAR   = 4'd1,
        ST_RD_WAIT  = 4'd2,
        ST_RD_LATCH = 4'd3,
        ST_RD_OUT   = 4'd4,
        ST_LD_MDR   = 4'd5,
        ST_WR_WAIT  = 4'd6,
        ST_WR_DONE  = 4'd7,
        ST_ABORT    = 4'd8
    } state_e;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: picks fetch or data when grant_en is high
// and remembers the owner; the pointer favours whoever was not granted last.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic req_fetch,
    input  logic req_data,
    input  logic grant_en,
    output logic owner,
    output logic ptr
);

    logic owner_q, owner_d;
    logic ptr_q, ptr_d;

    // The pointer holds the owner value that wins a tie.
    always_comb begin
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (grant_en && (req_fetch || req_data)) begin
            if (req_fetch && req_data) begin
                owner_d = ptr_q;
            end else if (req_data) begin
                owner_d = OWNER_DATA;
            end else begin
                owner_d = OWNER_FETCH;
            end
            ptr_d = ~owner_d;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            owner_q <= OWNER_FETCH;
            ptr_q   <= OWNER_FETCH;
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign owner = owner_q;
    assign ptr   = ptr_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates fetch/data requests and steps the
// MAR/MDR/memory strobes through read or write sequences with a wait timeout.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_we,
    input  logic mem_ready,
    output logic grant_data,
    output logic busy,
    output logic MARin,
    output logic MDRin,
    output logic select,
    output logic MDRout,
    output logic mem_read,
    output logic mem_write,
    output logic fetch_done,
    output logic data_done,
    output logic err
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_en;
    logic             owner;
    logic             ptr;
    logic             data_wins;
    logic             wait_expired;

    assign grant_en = (state_q == ST_IDLE) && (fetch_req || data_req);

    rr_arb2 u_arb (
        .clk       (clk),
        .clear     (clear),
        .req_fetch (fetch_req),
        .req_data  (data_req),
        .grant_en  (grant_en),
        .owner     (owner),
        .ptr       (ptr)
    );

    // data_we is only meaningful when this grant goes to the data requester.
    assign data_wins = data_req && (!fetch_req || (ptr == OWNER_DATA));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    assign wait_expired = (cnt_d == TIMEOUT_VAL);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_LD_MAR;
                    we_d    = data_wins && data_we;
                end
            end
            ST_LD_MAR:   state_d = we_q ? ST_LD_MDR : ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RD_LATCH;
                end else if (wait_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_RD_LATCH: state_d = ST_RD_OUT;
            ST_RD_OUT:   state_d = ST_IDLE;
            ST_LD_MDR:   state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_WR_DONE;
                end else if (wait_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_WR_DONE:  state_d = ST_IDLE;
            ST_ABORT:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on registered state, so clear silences them at once.
    always_comb begin
        logic done;
        busy       = (state_q != ST_IDLE);
        grant_data = busy && (owner == OWNER_DATA);
        MARin      = (state_q == ST_LD_MAR);
        MDRin      = (state_q == ST_RD_LATCH) || (state_q == ST_LD_MDR);
        select     = (state_q == ST_RD_LATCH);
        MDRout     = (state_q == ST_RD_OUT);
        mem_read   = (state_q == ST_RD_WAIT) || (state_q == ST_RD_LATCH);
        mem_write  = (state_q == ST_WR_WAIT);
        err        = (state_q == ST_ABORT);
        done       = (state_q == ST_RD_OUT) || (state_q == ST_WR_DONE) ||
                     (state_q == ST_ABORT);
        fetch_done = done && (owner == OWNER_FETCH);
        data_done  = done && (owner == OWNER_DATA);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and randomized operations
// compared cycle by cycle against a transaction-level model of the sequencer.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    localparam logic [10:0] GNT    = 11'h400;
    localparam logic [10:0] BUSY   = 11'h200;
    localparam logic [10:0] MAR    = 11'h100;
    localparam logic [10:0] MDRIN  = 11'h080;
    localparam logic [10:0] SEL    = 11'h040;
    localparam logic [10:0] MDROUT = 11'h020;
    localparam logic [10:0] MRD    = 11'h010;
    localparam logic [10:0] MWR    = 11'h008;
    localparam logic [10:0] FDONE  = 11'h004;
    localparam logic [10:0] DDONE  = 11'h002;
    localparam logic [10:0] ERR    = 11'h001;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic fetch_req = 1'b0;
    logic data_req = 1'b0;
    logic data_we = 1'b0;
    logic mem_ready = 1'b0;
    logic grant_data, busy, MARin, MDRin, select, MDRout;
    logic mem_read, mem_write, fetch_done, data_done, err;

    int checks = 0;
    int errors = 0;

    // Model state: pending requests, pending write flag and tie-break pointer.
    bit fPend = 1'b0;
    bit dPend = 1'b0;
    bit dWe = 1'b0;
    bit ptrData = 1'b0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
        .clk        (clk),
        .clear      (clear),
        .fetch_req  (fetch_req),
        .data_req   (data_req),
        .data_we    (data_we),
        .mem_ready  (mem_ready),
        .grant_data (grant_data),
        .busy       (busy),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .select     (select),
        .MDRout     (MDRout),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .fetch_done (fetch_done),
        .data_done  (data_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {grant_data, busy, MARin, MDRin, select, MDRout,
                       mem_read, mem_write, fetch_done, data_done, err};

    task automatic checkOutput(input logic [10:0] expected, input string tag, input int cyc);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, expected);
        end
    endtask

    // One operation from its IDLE cycle to its completion; optionally clear
    // is pulsed after the check of operation cycle clearAt.
    task automatic applyStimulus(input int delay, input int clearAt);
        bit own;
        bit wr;
        int nWait;
        logic [10:0] g;
        logic [10:0] doneBit;
        logic [10:0] expQ[$];
        int waitQ[$];

        own = (fPend && dPend) ? ptrData : dPend;
        ptrData = !own;
        wr = own && dWe;
        g = (own ? GNT : 11'h000) | BUSY;
        doneBit = own ? DDONE : FDONE;

        expQ.push_back(g | MAR);
        waitQ.push_back(-1);
        if (wr) begin
            expQ.push_back(g | MDRIN);
            waitQ.push_back(-1);
        end
        nWait = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
        for (int j = 0; j < nWait; j++) begin
            expQ.push_back(g | (wr ? MWR : MRD));
            waitQ.push_back(j);
        end
        if (delay >= TIMEOUT) begin
            expQ.push_back(g | doneBit | ERR);
            waitQ.push_back(-1);
        end else if (wr) begin
            expQ.push_back(g | doneBit);
            waitQ.push_back(-1);
        end else begin
            expQ.push_back(g | MRD | SEL | MDRIN);
            waitQ.push_back(-1);
            expQ.push_back(g | MDROUT | doneBit);
            waitQ.push_back(-1);
        end

        fetch_req = fPend;
        data_req = dPend;
        data_we = dWe;
        mem_ready = 1'($urandom_range(0, 1));
        checkOutput(11'h000, "idle_before_grant", 0);

        for (int k = 0; k < expQ.size(); k++) begin
            @(posedge clk);
            #1;
            if (own) begin
                data_req = 1'($urandom_range(0, 1));
                fetch_req = fPend;
            end else begin
                fetch_req = 1'($urandom_range(0, 1));
                data_req = dPend;
            end
            data_we = 1'($urandom_range(0, 1));
            mem_ready = (waitQ[k] >= 0) ? (waitQ[k] >= delay) : 1'($urandom_range(0, 1));
            checkOutput(expQ[k], own ? "data_op" : "fetch_op", k + 1);
            if (k == clearAt) begin
                fetch_req = 1'b0;
                data_req = 1'b0;
                #2;
                clear = 1'b0;
                #1;
                checkOutput(11'h000, "clear_async", k + 1);
                @(posedge clk);
                #1;
                checkOutput(11'h000, "clear_no_done", k + 2);
                clear = 1'b1;
                ptrData = 1'b0;
                fPend = 1'b0;
                dPend = 1'b0;
                return;
            end
        end

        if (own) dPend = 1'b0;
        else fPend = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        fetch_req = 1'b0;
        data_req = 1'b0;
        data_we = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        checkOutput(11'h000, "idle", 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        fetch_req = 1'b0;
        data_req = 1'b0;
        #2;
        clear = 1'b0;
        #1;
        checkOutput(11'h000, "clear_in_idle", 0);
        @(posedge clk);
        #1;
        clear = 1'b1;
        ptrData = 1'b0;
        fPend = 1'b0;
        dPend = 1'b0;
    endtask

    initial begin
        int r;
        int delay;

        #3;
        checkOutput(11'h000, "reset", 0);
        @(posedge clk);
        #1;
        checkOutput(11'h000, "reset_hold", 0);
        clear = 1'b1;

        $display("[TB] fetch read with memory ready");
        fPend = 1'b1;
        applyStimulus(0, -1);

        $display("[TB] data write with three wait cycles");
        dPend = 1'b1;
        dWe = 1'b1;
        applyStimulus(3, -1);

        $display("[TB] both requesters held: fetch, data, fetch");
        fPend = 1'b1;
        dPend = 1'b1;
        dWe = 1'b0;
        applyStimulus(0, -1);
        fPend = 1'b1;
        applyStimulus(1, -1);
        dPend = 1'b1;
        applyStimulus(2, -1);
        applyStimulus(2, -1);

        $display("[TB] timeouts and the last ready cycle before timeout");
        fPend = 1'b1;
        applyStimulus(20, -1);
        dPend = 1'b1;
        dWe = 1'b1;
        applyStimulus(TIMEOUT, -1);
        fPend = 1'b1;
        applyStimulus(TIMEOUT - 1, -1);

        $display("[TB] clear during write wait, then restart");
        dPend = 1'b1;
        dWe = 1'b1;
        applyStimulus(10, 3);
        dPend = 1'b1;
        dWe = 1'b1;
        applyStimulus(0, -1);

        $display("[TB] clear restores the fetch-first pointer");
        fPend = 1'b1;
        applyStimulus(0, -1);
        pulseClear();
        fPend = 1'b1;
        dPend = 1'b1;
        dWe = 1'b0;
        applyStimulus(0, -1);
        applyStimulus(0, -1);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            if (!fPend) fPend = 1'($urandom_range(0, 1));
            if (!dPend) begin
                dPend = 1'($urandom_range(0, 1));
                dWe = 1'($urandom_range(0, 1));
            end
            r = int'($urandom_range(0, 9));
            delay = (r < 7) ? r : ((r == 7) ? TIMEOUT - 1 : ((r == 8) ? TIMEOUT : TIMEOUT + 5));
            if (fPend || dPend) applyStimulus(delay, -1);
            else idleCycle();
        end
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
